// File: rtl/freq_meas_ctrl_if.sv
// Frequency-meter sequencer bundle: controller (master) <-> counter/display datapath (slave).
// testmode only exists when FREQ_MEAS_CTRL_TESTMODE_EN is defined.
`timescale 1ns/1ps
interface freq_meas_ctrl_if;
  logic       mode_ctl;
  logic       range_sel;
`ifdef FREQ_MEAS_CTRL_TESTMODE_EN
  logic [1:0] testmode;
`endif
  logic       hold;
  logic       cnt_ovf;
  logic       cnt_msd_zero;
  logic       cnt_clr;
  logic       cnt_en;
  logic       latch;
  logic       range_ext;
  logic       ovf_flag;
  logic [1:0] state_o;

`ifdef FREQ_MEAS_CTRL_TESTMODE_EN
  modport master (
    input  mode_ctl, range_sel, testmode, hold, cnt_ovf, cnt_msd_zero,
    output cnt_clr, cnt_en, latch, range_ext, ovf_flag, state_o
  );
  modport slave (
    output mode_ctl, range_sel, testmode, hold, cnt_ovf, cnt_msd_zero,
    input  cnt_clr, cnt_en, latch, range_ext, ovf_flag, state_o
  );
`else
  modport master (
    input  mode_ctl, range_sel, hold, cnt_ovf, cnt_msd_zero,
    output cnt_clr, cnt_en, latch, range_ext, ovf_flag, state_o
  );
  modport slave (
    output mode_ctl, range_sel, hold, cnt_ovf, cnt_msd_zero,
    input  cnt_clr, cnt_en, latch, range_ext, ovf_flag, state_o
  );
`endif
endinterface

// File: rtl/freq_meas_ctrl.sv
// Frequency-meter sequencer: CLEAR -> GATE -> SETTLE -> EVAL loop with auto/manual ranging, registered Moore outputs.
// Optional test-mode port and gate shortening enabled by FREQ_MEAS_CTRL_TESTMODE_EN.
`timescale 1ns/1ps
module freq_meas_ctrl #(
  parameter int GATE_CYCLES   = 50000000,
  parameter int RANGE_DIV     = 10,
  parameter int SETTLE_CYCLES = 4,
  parameter int CNT_W         = 26
) (
  input  logic             sysclk,
  input  logic             resetb,
  freq_meas_ctrl_if.master bus
);

  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_GATE, S_SETTLE, S_EVAL} state_t;

  localparam int G_STD   = GATE_CYCLES;
  localparam int G_EXT   = GATE_CYCLES / RANGE_DIV;
  localparam int G_STD_F = (G_STD / 1000 < 1) ? 1 : G_STD / 1000;
  localparam int G_EXT_F = (G_EXT / 1000 < 1) ? 1 : G_EXT / 1000;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] g_clr;
  logic [1:0]       tm;
  logic             auto_q, sticky, pend_rng, pend_ovf;
  logic             auto_clr, rng_clr, ovf_now;
  logic             dec_latch, dec_rng, dec_ovf;
  logic             clr_q, en_q, latch_q, range_q, ovf_q;
  logic [1:0]       st_q;
  logic             clr_d, en_d, latch_d;
  logic [1:0]       st_d;

`ifdef FREQ_MEAS_CTRL_TESTMODE_EN
  assign tm = bus.testmode;
`else
  assign tm = 2'b00;
`endif

  // Configuration resolved in CLEAR: forced ranges behave like manual mode.
  always_comb begin
    auto_clr = bus.mode_ctl && (tm == 2'b00 || tm == 2'b11);
    case (tm)
      2'b01:   rng_clr = 1'b0;
      2'b10:   rng_clr = 1'b1;
      default: rng_clr = auto_clr ? range_q : bus.range_sel;
    endcase
    case ({tm == 2'b11, rng_clr})
      2'b00:   g_clr = CNT_W'(G_STD);
      2'b01:   g_clr = CNT_W'(G_EXT);
      2'b10:   g_clr = CNT_W'(G_STD_F);
      default: g_clr = CNT_W'(G_EXT_F);
    endcase
  end

  // Window verdict, evaluated in the last SETTLE cycle so latch lands exactly on EVAL.
  always_comb begin
    ovf_now   = sticky | bus.cnt_ovf;
    dec_latch = 1'b0;
    dec_rng   = range_q;
    dec_ovf   = ovf_q;
    if (auto_q) begin
      if (ovf_now) begin
        if (!range_q) begin
          dec_rng = 1'b1;
        end else begin
          dec_latch = 1'b1;
          dec_ovf   = 1'b1;
        end
      end else if (range_q && bus.cnt_msd_zero) begin
        dec_rng = 1'b0;
      end else begin
        dec_latch = 1'b1;
        dec_ovf   = 1'b0;
      end
    end else begin
      dec_latch = 1'b1;
      dec_ovf   = ovf_now;
    end
    if (bus.hold) begin
      dec_latch = 1'b0;
      dec_ovf   = ovf_q;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   state_nxt = S_CLEAR;
      S_CLEAR:  state_nxt = S_GATE;
      S_GATE:   if (cnt == CNT_W'(1)) state_nxt = S_SETTLE;
      S_SETTLE: if (cnt == CNT_W'(1)) state_nxt = S_EVAL;
      S_EVAL:   state_nxt = S_CLEAR;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    clr_d   = (state_nxt == S_CLEAR);
    en_d    = (state_nxt == S_GATE);
    latch_d = (state_nxt == S_EVAL) && dec_latch;
    case (state_nxt)
      S_IDLE:  st_d = 2'd0;
      S_CLEAR: st_d = 2'd1;
      default: st_d = 2'd2;
    endcase
  end

  always_ff @(posedge sysclk or negedge resetb) begin
    if (!resetb) begin
      state    <= S_IDLE;
      cnt      <= '0;
      auto_q   <= 1'b0;
      sticky   <= 1'b0;
      pend_rng <= 1'b0;
      pend_ovf <= 1'b0;
      clr_q    <= 1'b0;
      en_q     <= 1'b0;
      latch_q  <= 1'b0;
      range_q  <= 1'b0;
      ovf_q    <= 1'b0;
      st_q     <= 2'd0;
    end else begin
      state   <= state_nxt;
      clr_q   <= clr_d;
      en_q    <= en_d;
      latch_q <= latch_d;
      st_q    <= st_d;
      case (state)
        S_CLEAR: begin
          cnt     <= g_clr;
          auto_q  <= auto_clr;
          range_q <= rng_clr;
          sticky  <= 1'b0;
        end
        S_GATE: begin
          sticky <= ovf_now;
          cnt    <= (cnt == CNT_W'(1)) ? CNT_W'(SETTLE_CYCLES) : cnt - CNT_W'(1);
        end
        S_SETTLE: begin
          sticky <= ovf_now;
          cnt    <= cnt - CNT_W'(1);
          if (state_nxt == S_EVAL) begin
            pend_rng <= dec_rng;
            pend_ovf <= dec_ovf;
          end
        end
        S_EVAL: begin
          range_q <= pend_rng;
          ovf_q   <= pend_ovf;
        end
        default: ;
      endcase
    end
  end

  assign bus.cnt_clr   = clr_q;
  assign bus.cnt_en    = en_q;
  assign bus.latch     = latch_q;
  assign bus.range_ext = range_q;
  assign bus.ovf_flag  = ovf_q;
  assign bus.state_o   = st_q;

endmodule

// File: tb/tb_freq_meas_ctrl.sv
// Scoreboarded bench for freq_meas_ctrl: expected latch events and gate lengths are queued, a monitor pops and compares.
`timescale 1ns/1ps
module tb_freq_meas_ctrl;
  typedef struct {
    int   cyc;
    logic rng;
    logic ovf;
  } lat_t;

  logic sysclk = 1'b0;
  logic resetb = 1'b0;
  int   cyc;
  int   n_chk = 0;
  int   n_fail = 0;
  lat_t lq[$];
  int   gq[$];

  freq_meas_ctrl_if bus();

  freq_meas_ctrl #(
    .GATE_CYCLES(1000), .RANGE_DIV(10), .SETTLE_CYCLES(4), .CNT_W(26)
  ) dut (
    .sysclk(sysclk),
    .resetb(resetb),
    .bus(bus)
  );

  always #5 sysclk = ~sysclk;

  always @(posedge sysclk or negedge resetb)
    if (!resetb) cyc <= 0;
    else         cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic wait_cyc(input int n);
    int k = 0;
    while (cyc < n && k < 20000) begin
      @(negedge sysclk);
      k++;
    end
    if (cyc < n) chk("wait_timeout", cyc, n);
  endtask

  task automatic push_lat(input int c, input logic r, input logic o);
    lat_t it;
    it.cyc = c; it.rng = r; it.ovf = o;
    lq.push_back(it);
  endtask

  task automatic pulse_ovf();
    bus.cnt_ovf = 1'b1;
    @(negedge sysclk);
    bus.cnt_ovf = 1'b0;
  endtask

  // Asserts reset between clock edges and checks the outputs fall before any edge.
  task automatic async_rst(input string tag);
    #2 resetb = 1'b0;
    #1;
    chk({tag, "_cnt_en"},    bus.cnt_en,    0);
    chk({tag, "_range_ext"}, bus.range_ext, 0);
    chk({tag, "_ovf_flag"},  bus.ovf_flag,  0);
    chk({tag, "_state_o"},   bus.state_o,   0);
    @(negedge sysclk);
    @(negedge sysclk);
    #2 resetb = 1'b1;
    #1;
    chk({tag, "_post_rel_state"}, bus.state_o, 0);
    chk({tag, "_post_rel_clr"},   bus.cnt_clr, 0);
  endtask

  // Monitor
  int   run = 0;
  bit   pend = 0;
  logic pend_exp;
  lat_t mit;
  always @(negedge sysclk) begin
    if (!resetb) begin
      run  = 0;
      pend = 0;
    end else begin
      if (pend) begin
        chk("ovf_flag_after_latch", bus.ovf_flag, pend_exp);
        pend = 0;
      end
      if (bus.cnt_en) run++;
      else if (run != 0) begin
        if (gq.size() == 0) chk("unexpected_gate_len", run, -1);
        else                chk("gate_len", run, gq.pop_front());
        run = 0;
      end
      if (bus.latch) begin
        if (lq.size() == 0) chk("unexpected_latch_cyc", cyc, -1);
        else begin
          mit = lq.pop_front();
          chk("latch_cyc",   cyc,           mit.cyc);
          chk("latch_range", bus.range_ext, mit.rng);
          pend_exp = mit.ovf;
          pend     = 1;
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached at cyc %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.mode_ctl = 1'b1; bus.range_sel = 1'b0; bus.hold = 1'b0;
    bus.cnt_ovf = 1'b0; bus.cnt_msd_zero = 1'b0;
`ifdef FREQ_MEAS_CTRL_TESTMODE_EN
    bus.testmode = 2'b00;
`endif
    repeat (3) @(negedge sysclk);
    chk("rst_cnt_clr", bus.cnt_clr, 0);
    chk("rst_cnt_en",  bus.cnt_en,  0);
    chk("rst_latch",   bus.latch,   0);
    chk("rst_state",   bus.state_o, 0);

    // Auto mode: steady, up-range, ext latch, down-range, ext overflow, hold.
    push_lat(1006, 0, 0); push_lat(2012, 0, 0); push_lat(3124, 1, 0);
    push_lat(4342, 1, 1); push_lat(4554, 1, 0);
    foreach (gq[i]) gq.delete(i);
    gq = '{1000, 1000, 1000, 100, 100, 1000, 100, 100, 100};
    #2 resetb = 1'b1;
    wait_cyc(1);
    chk("a_clear_pulse", bus.cnt_clr, 1);
    chk("a_clear_state", bus.state_o, 1);
    wait_cyc(2);
    chk("a_gate_en",     bus.cnt_en,  1);
    chk("a_gate_clr",    bus.cnt_clr, 0);
    chk("a_gate_state",  bus.state_o, 2);
    wait_cyc(1003);
    chk("a_settle_en",    bus.cnt_en,  0);
    chk("a_settle_state", bus.state_o, 2);
    wait_cyc(2500); pulse_ovf();
    wait_cyc(3030); chk("a_uprange", bus.range_ext, 1);
    wait_cyc(3200); bus.cnt_msd_zero = 1'b1;
    wait_cyc(3240); bus.cnt_msd_zero = 1'b0;
    chk("a_downrange", bus.range_ext, 0);
    wait_cyc(3500); pulse_ovf();
    wait_cyc(4300); pulse_ovf();
    wait_cyc(4330); chk("a_ovf_before", bus.ovf_flag, 0);
    wait_cyc(4350); bus.hold = 1'b1;
    chk("a_ovf_set", bus.ovf_flag, 1);
    wait_cyc(4450);
    chk("a_hold_ovf",   bus.ovf_flag,  1);
    chk("a_hold_range", bus.range_ext, 1);
    wait_cyc(4455); bus.hold = 1'b0;
    wait_cyc(4600);
    chk("a_pre_rst_en",    bus.cnt_en,    1);
    chk("a_pre_rst_range", bus.range_ext, 1);
    async_rst("a_rst");

    // Manual mode: range_sel only honoured in CLEAR; latch every window.
    bus.mode_ctl = 1'b0; bus.range_sel = 1'b0; bus.cnt_msd_zero = 1'b1;
    push_lat(1006, 0, 0); push_lat(1112, 1, 1);
    gq.push_back(1000); gq.push_back(100);
    wait_cyc(500); bus.range_sel = 1'b1;
    wait_cyc(600);  chk("m_mid_gate_range", bus.range_ext, 0);
    wait_cyc(1010); chk("m_next_clear_range", bus.range_ext, 1);
    wait_cyc(1050); pulse_ovf();
    wait_cyc(1060); bus.range_sel = 1'b0;
    wait_cyc(1200);
    chk("m_ovf_flag", bus.ovf_flag,  1);
    chk("m_range_back", bus.range_ext, 0);
    wait_cyc(1500);
    chk("m_pre_rst_ovf", bus.ovf_flag, 1);
    chk("m_pre_rst_en",  bus.cnt_en,   1);
    async_rst("m_rst");

    // Reset at gate cycle 500, then a clean auto window.
    bus.mode_ctl = 1'b1; bus.cnt_msd_zero = 1'b0;
    wait_cyc(501);
    chk("r_pre_rst_en", bus.cnt_en, 1);
    async_rst("r_rst");
    push_lat(1006, 0, 0);
    gq.push_back(1000);
    wait_cyc(1);
    chk("r_clear_pulse", bus.cnt_clr, 1);
    wait_cyc(1010);
    chk("latch_queue_left", lq.size(), 0);
    chk("gate_queue_left",  gq.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
